// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle EX-stage ALU: op codes, FSM states, default width.
// The optional fast-shift build is selected with the EX_ALU_FAST_SHIFT_EN macro.
package alu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ex_alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/ex_alu_multicycle_serial_shifter.sv
// One-bit-per-cycle shifter: holds the operand and op, counts the remaining shifts
// down, and flags the cycle whose shift produces the final value.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int SHW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  alu_op_e               op_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SHW-1:0]        shamt_in,
  output logic [DATA_WIDTH-1:0] data_next,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [SHW-1:0]        count_q, count_d;
  alu_op_e               op_q, op_d;

  always_comb begin
    case (op_q)
      OP_SLL:  data_next = {shift_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  data_next = {shift_q[DATA_WIDTH-1], shift_q[DATA_WIDTH-1:1]};
      default: data_next = {1'b0, shift_q[DATA_WIDTH-1:1]};
    endcase
  end

  // The edge that sees count==1 performs the last shift; data_next is the result.
  assign done = (count_q == SHW'(1));

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    op_d    = op_q;
    if (load) begin
      shift_d = data_in;
      count_d = shamt_in;
      op_d    = op_in;
    end else if (count_q != '0) begin
      shift_d = data_next;
      count_d = count_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
      op_q    <= OP_AND;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: rtl/ex_alu_multicycle.sv
// EX-stage ALU with registered result and valid/ready handshake. Shifts iterate one
// bit per cycle unless EX_ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module ex_alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int SHW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [SHW-1:0]        shamt;

  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (Operation)
      OP_AND: alu_result = SrcA & SrcB;
      OP_OR:  alu_result = SrcA | SrcB;
      OP_ADD: alu_result = SrcA + SrcB;
      OP_SUB: alu_result = SrcA - SrcB;
      OP_BEQ: alu_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef EX_ALU_FAST_SHIFT_EN
      OP_SLL: alu_result = SrcA << shamt;
      OP_SRL: alu_result = SrcA >> shamt;
      OP_SRA: alu_result = $signed(SrcA) >>> shamt;
`else
      // Only reached with shamt==0 here; nonzero amounts go through the serial shifter.
      OP_SLL, OP_SRL, OP_SRA: alu_result = SrcA;
`endif
      default: alu_result = '0;
    endcase
  end

`ifdef EX_ALU_FAST_SHIFT_EN

  assign in_ready = 1'b1;

  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (in_valid) begin
      result_d       = alu_result;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`else

  ex_alu_state_e         state_q, state_d;
  logic                  shift_load;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_result;

  assign in_ready   = (state_q == IDLE);
  assign shift_load = in_valid && in_ready && is_shift_op(Operation) && (shamt != '0);

  serial_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SHW       (SHW)
  ) u_serial_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (shift_load),
    .op_in    (alu_op_e'(Operation)),
    .data_in  (SrcA),
    .shamt_in (shamt),
    .data_next(shift_result),
    .done     (shift_done)
  );

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (shift_load) begin
            state_d = SHIFT;
          end else begin
            result_d       = alu_result;
            result_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          result_d       = shift_result;
          result_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`endif

  assign result_valid = result_valid_q;
  assign ALUResult    = result_q;
  assign Zero         = (result_q == '0);

endmodule

// File: tb/tb_ex_alu_multicycle.sv
// Directed, table-driven bench for ex_alu_multicycle; honours EX_ALU_FAST_SHIFT_EN
// for the expected shift latencies.
module tb_ex_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        result_valid;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t sc_vec[10];
  vec_t sh_vec[7];

  ex_alu_multicycle dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Operation   (Operation),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .result_valid(result_valid),
    .ALUResult   (ALUResult),
    .Zero        (Zero)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int slow_lat);
`ifdef EX_ALU_FAST_SHIFT_EN
    return (slow_lat > 0) ? 1 : slow_lat;
`else
    return slow_lat;
`endif
  endfunction

  // Issue one op from idle, then count cycles to result_valid (bounded).
  task automatic run_op(input vec_t v);
    int cycles;
    @(negedge clk);
    check({v.name, "_ready"}, {31'b0, in_ready}, 32'd1);
    Operation = v.op; SrcA = v.a; SrcB = v.b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    SrcA = 32'hDEAD_BEEF; SrcB = 32'h0000_0003;
    cycles = 1;
    while (!result_valid && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    check({v.name, "_valid"}, {31'b0, result_valid}, 32'd1);
    check({v.name, "_lat"}, cycles, exp_lat(v.lat));
    check({v.name, "_result"}, ALUResult, v.exp);
    check({v.name, "_zero"}, {31'b0, Zero}, {31'b0, (v.exp == 32'd0)});
    $display("txn %s op=%b a=0x%08h b=0x%08h result=0x%08h lat=%0d", v.name, v.op, v.a, v.b,
             ALUResult, cycles);
    @(negedge clk);
    check({v.name, "_pulse"}, {31'b0, result_valid}, 32'd0);
  endtask

  initial begin
    int busy;
    int early;
    int seen;

    sc_vec[0] = mk(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "add_wrap");
    sc_vec[1] = mk(4'b0011, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, "sub_neg");
    sc_vec[2] = mk(4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, "slt_true");
    sc_vec[3] = mk(4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001, 1, "beq_eq");
    sc_vec[4] = mk(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, "and");
    sc_vec[5] = mk(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1, "or");
    sc_vec[6] = mk(4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, "slt_false");
    sc_vec[7] = mk(4'b1000, 32'h0000_0007, 32'h0000_0008, 32'h0000_0000, 1, "beq_ne");
    sc_vec[8] = mk(4'b0010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, "add");
    sc_vec[9] = mk(4'b1111, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1, "unknown");

    sh_vec[0] = mk(4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1,  "sll_sh0");
    sh_vec[1] = mk(4'b0101, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 32, "srl_31");
    sh_vec[2] = mk(4'b0100, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 6,  "sll_5");
    sh_vec[3] = mk(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5,  "sra_4");
    sh_vec[4] = mk(4'b0101, 32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 2,  "srl_1");
    sh_vec[5] = mk(4'b0111, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 5,  "sra_pos");
    sh_vec[6] = mk(4'b0100, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 32, "sll_31");

    reset = 1'b1; in_valid = 1'b0; Operation = 4'b0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'b0, Zero}, 32'd1);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;

    // Single-cycle ops issued back to back: each result appears one cycle later.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      Operation = sc_vec[i].op; SrcA = sc_vec[i].a; SrcB = sc_vec[i].b; in_valid = 1'b1;
      @(negedge clk);
      check({sc_vec[i].name, "_valid"}, {31'b0, result_valid}, 32'd1);
      check({sc_vec[i].name, "_result"}, ALUResult, sc_vec[i].exp);
      check({sc_vec[i].name, "_zero"}, {31'b0, Zero}, {31'b0, (sc_vec[i].exp == 32'd0)});
      $display("txn %s op=%b a=0x%08h b=0x%08h result=0x%08h", sc_vec[i].name, sc_vec[i].op,
               sc_vec[i].a, sc_vec[i].b, ALUResult);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_pulse_end", {31'b0, result_valid}, 32'd0);

    for (int i = 0; i < 7; i++) run_op(sh_vec[i]);

    // SRA with the next op held on in_valid throughout the shift.
    @(negedge clk);
    Operation = 4'b0111; SrcA = 32'h8000_0000; SrcB = 32'h0000_0004; in_valid = 1'b1;
    @(negedge clk);
    Operation = 4'b0010; SrcA = 32'h0000_0001; SrcB = 32'h0000_0001;
    busy = 0; early = 0;
    while (!in_ready && busy < 40) begin
      if (result_valid) early++;
      busy++;
      @(negedge clk);
    end
`ifdef EX_ALU_FAST_SHIFT_EN
    check("sra_hold_busy", busy, 0);
`else
    check("sra_hold_busy", busy, 4);
`endif
    check("sra_hold_early", early, 0);
    check("sra_hold_valid", {31'b0, result_valid}, 32'd1);
    check("sra_hold_result", ALUResult, 32'hF800_0000);
    $display("txn sra_hold result=0x%08h busy=%0d", ALUResult, busy);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_add_valid", {31'b0, result_valid}, 32'd1);
    check("held_add_result", ALUResult, 32'h0000_0002);
    $display("txn held_add result=0x%08h", ALUResult);

    // Reset in the middle of a long shift discards it.
    @(negedge clk);
    Operation = 4'b0100; SrcA = 32'h0000_0001; SrcB = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_result", ALUResult, 32'd0);
    check("midrst_zero", {31'b0, Zero}, 32'd1);
    check("midrst_valid", {31'b0, result_valid}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_ready_after", {31'b0, in_ready}, 32'd1);
    $display("txn mid_shift_reset result=0x%08h stray_valid=%0d", ALUResult, seen);

    run_op(mk(4'b0010, 32'd3, 32'd4, 32'd7, 1, "post_rst_add"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_alu_multicycle.md
# ex_alu_multicycle

Multi-cycle execute unit that consumes the 4-bit `Operation` code from the ALU controller, plus the two datapath operands, and produces a registered `ALUResult` and `Zero` flag. Single-cycle ops (add/sub/and/or/slt/beq) complete in one cycle. Shifts run iteratively, one bit per cycle, unless the fast-shift build option is enabled. It sits in the EX stage between operand muxing and the pipeline's EX/MEM register, which holds the issuing stage off through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, operand/result width; `SHW = $clog2(DATA_WIDTH)`
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `in_valid` input 1: operands and `Operation` valid this cycle
- `in_ready` output 1: unit can accept; high only in IDLE
- `Operation` input 4: ALU op code from controller
- `SrcA` input DATA_WIDTH: operand A
- `SrcB` input DATA_WIDTH: operand B; shift amount = `SrcB[SHW-1:0]`
- `result_valid` output 1: one-cycle pulse, result ready
- `ALUResult` output DATA_WIDTH: registered result, held until next completion
- `Zero` output 1: `ALUResult == 0`, combinational from the register

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 SUB
  - 0100 SLL
  - 0101 SRL
  - 0111 SRA
  - 1000 BEQ: result = (A==B) ? 1 : 0
  - 1100 SLT: signed A<B ? 1 : 0
  - Any other code: result 0, single-cycle
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`:
    - Non-shift op, or shift with shamt=0: result is computed and registered; `result_valid` pulses the next cycle; stay in IDLE.
    - Shift with shamt>0: latch A into the shift register, latch the op, load `count`=shamt; go to SHIFT.
  - SHIFT: `in_ready`=0. Each cycle, shift by 1 (SRA replicates the MSB) and decrement `count`. When `count` reaches 1, write the result, pulse `result_valid` the next cycle, and return to IDLE.
- `in_valid` while `in_ready`=0 is ignored; the upstream stage must hold it.
- Back-to-back: a new op may be accepted in the same cycle `result_valid` is high.
- Operands are sampled only on acceptance. Later changes to `SrcA`/`SrcB` have no effect.
- Reset, asynchronous at any point including mid-shift:
  - State → IDLE.
  - `ALUResult`=0, hence `Zero`=1.
  - `result_valid`=0, `count`=0.
  - `in_ready`=1 once in IDLE.
  - The in-flight op is discarded with no `result_valid`.

## Timing
- Latency from the accepting edge to `result_valid`:
  - Non-shift: 1 cycle.
  - Shift: shamt+1 cycles; max DATA_WIDTH (32 at default).
  - Shift with shamt=0: 1 cycle.
- Throughput: 1 op/cycle for non-shift ops. A shift blocks the unit for shamt cycles.
- `ALUResult` changes only on the edge that raises `result_valid`.

## Configuration
- `EX_ALU_FAST_SHIFT_EN` defined: shifts use a single-cycle barrel shifter with the same 1-cycle latency as other ops. The SHIFT state and `count` are not built, and `in_ready` is constantly 1 outside reset.
- Undefined (default): iterative shifting as described above.
- Results are bit-identical in both builds; only latency differs.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum with the op codes above.
  - `ex_alu_state_e` enum (IDLE, SHIFT).
  - Localparam `DATA_WIDTH_DEFAULT`=32.
- Sub-module `serial_shifter`: shift register, down counter, and done strobe, instantiated only when the macro is undefined. Top level holds the FSM, the single-cycle datapath, and the result register.

## Test plan
- Reset mid-shift: start SLL A=1, B=20; assert `reset` at cycle 5 → no `result_valid`, `ALUResult`=0, `Zero`=1, `in_ready`=1.
- Single-cycle ops, back-to-back:
  - ADD 0xFFFFFFFF+1 → 0, `Zero`=1.
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT -1<1 → 1.
  - BEQ 7,7 → 1.
  - Each result pulses 1 cycle after acceptance.
- SRA A=0x80000000, B=4 → 0xF8000000 after 5 cycles. `in_ready`=0 for 4 cycles; `in_valid` held during the shift is not accepted until IDLE.
- Shift edges:
  - SLL A=0x1, B=0x20 (shamt=0) → 0x1 in 1 cycle.
  - SRL A=0xFFFFFFFF, B=31 → 0x1 after 32 cycles.
- Unknown code 1111, A=3, B=3 → 0, `Zero`=1, 1-cycle latency. Repeat the shift cases with `EX_ALU_FAST_SHIFT_EN` → same values, 1-cycle latency.
